ram_io_responder: RTL and testbench

Responder end of the byte-wide RAM bus driven by the memory controller: accepts one byte address per cycle with a write strobe, returns read data one cycle later, and backs pressure with `io_buffer_full`. It contains the main byte-addressable RAM plus a memory-mapped I/O window: a TX FIFO toward the serial transmitter and an RX FIFO from the receiver. It sits between the memory controller and the board RAM/UART, in place of a bare RAM model.

---
 rtl/ram_io_responder_pkg.sv | 47 ++++
 rtl/ram_io_responder_byte_fifo.sv | 60 ++++++
 rtl/ram_io_responder.sv | 117 +++++++++++
 tb/tb_ram_io_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_io_responder_pkg.sv
// Shared address map, status layout and access decode for the RAM/IO responder.
package ram_io_responder_pkg;

    localparam int ADDR_W = 32;
    localparam int BYTE_W = 8;

    localparam logic [ADDR_W-1:0] IO_BASE       = 32'h0003_0000;
    localparam logic [15:0]       IO_DATA_OFS   = 16'h0000;
    localparam logic [15:0]       IO_STATUS_OFS = 16'h0004;

    localparam int STAT_TX_FULL     = 0;
    localparam int STAT_RX_NONEMPTY = 1;
    localparam int STAT_TX_OVERFLOW = 2;

    typedef enum logic [1:0] {
        ACC_RAM,
        ACC_IO_DATA,
        ACC_IO_STATUS,
        ACC_IO_OTHER
    } access_e;

    // Only bits [17:16] select the I/O window; the low half-word is the register offset.
    function automatic access_e decode_access(input logic [17:0] addr);
        access_e acc;
        if (addr[17:16] != IO_BASE[17:16])
            acc = ACC_RAM;
        else if (addr[15:0] == IO_DATA_OFS)
            acc = ACC_IO_DATA;
        else if (addr[15:0] == IO_STATUS_OFS)
            acc = ACC_IO_STATUS;
        else
            acc = ACC_IO_OTHER;
        return acc;
    endfunction

    function automatic logic [BYTE_W-1:0] pack_status(input logic tx_full,
                                                      input logic rx_nonempty,
                                                      input logic tx_overflow);
        logic [BYTE_W-1:0] s;
        s                   = '0;
        s[STAT_TX_FULL]     = tx_full;
        s[STAT_RX_NONEMPTY] = rx_nonempty;
        s[STAT_TX_OVERFLOW] = tx_overflow;
        return s;
    endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte FIFO with power-of-two depth; a push into a full FIFO is accepted when a pop frees a slot.
module byte_fifo #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    output logic [7:0]       head,
    output logic [PTR_W:0]   count,
    output logic [PTR_W:0]   count_next,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok)
            count_next = count + CNT_ONE;
        else if (pop_ok && !push_ok)
            count_next = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
        end
    end

    // NOTE: storage is deliberately not reset; count gates which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ram_io_responder.sv
// Byte-wide RAM responder with a memory-mapped TX/RX FIFO window and 1-cycle registered reads.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH     = 8,
    parameter int FULL_MARGIN    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_a,
    input  logic [BYTE_W-1:0] mem_dout,
    input  logic              mem_wr,
    output logic [BYTE_W-1:0] mem_din,
    output logic              io_buffer_full,
    output logic [BYTE_W-1:0] io_tx_data,
    output logic              io_tx_valid,
    input  logic              io_tx_ready,
    input  logic [BYTE_W-1:0] io_rx_data,
    input  logic              io_rx_valid
);

    localparam int              CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_THRESH = CNT_W'(FIFO_DEPTH - FULL_MARGIN);

    access_e           acc;
    logic              ram_we;
    logic              tx_push;
    logic              tx_pop;
    logic              rx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_empty;
    logic [BYTE_W-1:0] rx_head;
    logic [CNT_W-1:0]  tx_count;
    logic [CNT_W-1:0]  tx_count_next;
    logic [CNT_W-1:0]  rx_count;
    logic [CNT_W-1:0]  rx_count_next;
    logic              rx_full;
    logic              tx_overflow;
    logic              rd_is_io;
    logic [BYTE_W-1:0] io_rdata;
    logic [BYTE_W-1:0] io_rdata_next;
    logic [BYTE_W-1:0] ram_rdata;
    logic [BYTE_W-1:0] ram [2**RAM_ADDR_WIDTH];
    logic              unused_bits;

    assign unused_bits = ^{mem_a[ADDR_W-1:18], tx_count, rx_count, rx_count_next, rx_full};

    assign acc     = decode_access(mem_a[17:0]);
    assign ram_we  = mem_wr && (acc == ACC_RAM) && !rst;
    assign tx_push = mem_wr && (acc == ACC_IO_DATA);
    assign rx_pop  = !mem_wr && (acc == ACC_IO_DATA);
    assign tx_pop  = io_tx_valid && io_tx_ready;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (tx_push),
        .pop        (tx_pop),
        .din        (mem_dout),
        .head       (io_tx_data),
        .count      (tx_count),
        .count_next (tx_count_next),
        .full       (tx_full),
        .empty      (tx_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (io_rx_valid),
        .pop        (rx_pop),
        .din        (io_rx_data),
        .head       (rx_head),
        .count      (rx_count),
        .count_next (rx_count_next),
        .full       (rx_full),
        .empty      (rx_empty)
    );

    assign io_tx_valid = !tx_empty;

    always_comb begin
        io_rdata_next = '0;
        if (!mem_wr) begin
            case (acc)
                ACC_IO_DATA:   io_rdata_next = rx_empty ? '0 : rx_head;
                ACC_IO_STATUS: io_rdata_next = pack_status(tx_full, !rx_empty, tx_overflow);
                default:       io_rdata_next = '0;
            endcase
        end
    end

    // RAM keeps its own output register so the array maps onto block RAM; the I/O path muxes after it.
    always_ff @(posedge clk) begin
        if (ram_we) ram[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_dout;
        ram_rdata <= ram[mem_a[RAM_ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_overflow    <= 1'b0;
            rd_is_io       <= 1'b1;
            io_rdata       <= '0;
            io_buffer_full <= 1'b0;
        end else begin
            if (tx_push && tx_full && !tx_pop) tx_overflow <= 1'b1;
            rd_is_io       <= mem_wr || (acc != ACC_RAM);
            io_rdata       <= io_rdata_next;
            io_buffer_full <= (tx_count_next >= FULL_THRESH);
        end
    end

    assign mem_din = rd_is_io ? io_rdata : ram_rdata;

endmodule

// File: tb/tb_ram_io_responder.sv
// Randomised + directed bench for ram_io_responder against a queue/array reference model.
module tb_ram_io_responder;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_a = '0;
    logic [7:0]  mem_dout = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid;
    logic        io_tx_ready = 1'b0;
    logic [7:0]  io_rx_data = '0;
    logic        io_rx_valid = 1'b0;

    always #5 clk = ~clk;

    ram_io_responder #(
        .RAM_ADDR_WIDTH (17),
        .FIFO_DEPTH     (DEPTH),
        .FULL_MARGIN    (MARGIN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .io_tx_data     (io_tx_data),
        .io_tx_valid    (io_tx_valid),
        .io_tx_ready    (io_tx_ready),
        .io_rx_data     (io_rx_data),
        .io_rx_valid    (io_rx_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: sparse RAM, two queues and a sticky overflow flag.
    logic [7:0] ram_m [int];
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    logic       ovf_m = 1'b0;
    logic       exp_tx_valid = 1'b0;
    logic [7:0] exp_tx_data = '0;
    logic       exp_bf = 1'b0;
    logic [7:0] exp_din = '0;
    logic       din_chk = 1'b0;
    logic       cmp_en = 1'b0;

    task automatic model_update();
        logic [7:0] rd;
        bit         rd_known;
        bit         pop_tx;
        bit         is_io;
        int         ra;
        rd       = '0;
        rd_known = 1;
        if (rst) begin
            txq.delete();
            rxq.delete();
            ovf_m = 1'b0;
        end else begin
            is_io    = (mem_a[17:16] == 2'b11);
            ra       = int'(mem_a[16:0]);
            pop_tx   = (txq.size() > 0) && io_tx_ready;
            rd_known = !mem_wr;
            if (!is_io) begin
                if (mem_wr) ram_m[ra] = mem_dout;
                else if (ram_m.exists(ra)) rd = ram_m[ra];
                else rd_known = 0;
            end else if (!mem_wr && mem_a[15:0] == 16'h0000) begin
                if (rxq.size() > 0) rd = rxq.pop_front();
            end else if (!mem_wr && mem_a[15:0] == 16'h0004) begin
                rd = {5'b0, ovf_m, (rxq.size() > 0), (txq.size() == DEPTH)};
            end
            if (pop_tx) void'(txq.pop_front());
            if (mem_wr && is_io && mem_a[15:0] == 16'h0000) begin
                if (txq.size() < DEPTH) txq.push_back(mem_dout);
                else ovf_m = 1'b1;
            end
            if (io_rx_valid && rxq.size() < DEPTH) rxq.push_back(io_rx_data);
        end
        exp_din      = rd;
        din_chk      = rd_known;
        exp_tx_valid = (txq.size() > 0);
        exp_tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
        exp_bf       = (txq.size() >= DEPTH - MARGIN);
        cmp_en       = 1'b1;
    endtask

    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            check("tx_valid", io_tx_valid, exp_tx_valid);
            if (exp_tx_valid) check("tx_data", io_tx_data, exp_tx_data);
            check("buffer_full", io_buffer_full, exp_bf);
            if (din_chk) check("mem_din", mem_din, exp_din);
        end
    end

    task automatic op(input logic w, input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        mem_wr   = w;
        mem_a    = a;
        mem_dout = d;
        model_update();
        @(posedge clk);
        #3;
    endtask

    task automatic rx_strobe(input logic [7:0] d);
        io_rx_valid = 1'b1;
        io_rx_data  = d;
        op(1'b0, 32'h0, 8'h00);
        io_rx_valid = 1'b0;
    endtask

    logic [7:0] seq_bytes [4];

    initial begin
        seq_bytes[0] = 8'h3C; seq_bytes[1] = 8'hC3; seq_bytes[2] = 8'h5A; seq_bytes[3] = 8'h96;

        rst = 1'b1;
        op(1'b0, 32'h0, 8'h00);
        op(1'b0, 32'h0, 8'h00);
        check("reset tx_valid", io_tx_valid, 1'b0);
        check("reset buffer_full", io_buffer_full, 1'b0);
        check("reset mem_din", mem_din, 8'h00);
        rst = 1'b0;

        // RAM write then read-after-write, then four back-to-back reads
        op(1'b1, 32'h0001_0010, 8'hA5);
        op(1'b0, 32'h0001_0010, 8'h00);
        check("ram readback", mem_din, 8'hA5);
        check("model ram readback", exp_din, 8'hA5);
        for (int i = 0; i < 4; i++) op(1'b1, 32'h0001_0011 + 32'(i), seq_bytes[i]);
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 32'h0001_0011 + 32'(i), 8'h00);
            check("ram burst", mem_din, seq_bytes[i]);
        end

        // TX backpressure and overflow
        io_tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            op(1'b1, 32'h0003_0000, 8'h41 + 8'(i));
            if (i == 4) check("bf below margin", io_buffer_full, 1'b0);
            if (i == 5) check("bf at margin", io_buffer_full, 1'b1);
        end
        op(1'b0, 32'h0003_0004, 8'h00);
        check("status at 6", mem_din, 8'h00);
        op(1'b1, 32'h0003_0000, 8'h47);
        op(1'b1, 32'h0003_0000, 8'h48);
        op(1'b1, 32'h0003_0000, 8'h49);
        op(1'b0, 32'h0003_0004, 8'h00);
        check("status full+ovf", mem_din, 8'h05);
        check("model status full+ovf", exp_din, 8'h05);

        // TX drain
        check("tx head", io_tx_data, 8'h41);
        io_tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            op(1'b0, 32'h0, 8'h00);
            if (i < 8) check("drain data", io_tx_data, 8'h41 + 8'(i));
            check("drain bf", io_buffer_full, (8 - i) >= 6);
        end
        check("drained valid", io_tx_valid, 1'b0);
        io_tx_ready = 1'b0;

        // Simultaneous push/pop on a full TX FIFO
        for (int i = 0; i < 8; i++) op(1'b1, 32'h0003_0000, 8'h50 + 8'(i));
        io_tx_ready = 1'b1;
        op(1'b1, 32'h0003_0000, 8'h58);
        io_tx_ready = 1'b0;
        check("model simul count", txq.size(), 8);
        op(1'b0, 32'h0003_0004, 8'h00);
        check("simul still full", mem_din, 8'h05);
        io_tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            op(1'b0, 32'h0, 8'h00);
            if (i < 8) check("simul drain", io_tx_data, 8'h51 + 8'(i));
        end
        io_tx_ready = 1'b0;

        // RX path
        rx_strobe(8'h55);
        rx_strobe(8'h66);
        op(1'b0, 32'h0003_0004, 8'h00);
        check("rx nonempty 1", mem_din[1], 1'b1);
        op(1'b0, 32'h0003_0000, 8'h00);
        check("rx pop 0x55", mem_din, 8'h55);
        op(1'b0, 32'h0003_0004, 8'h00);
        check("rx nonempty 2", mem_din[1], 1'b1);
        op(1'b0, 32'h0003_0000, 8'h00);
        check("rx pop 0x66", mem_din, 8'h66);
        op(1'b0, 32'h0003_0004, 8'h00);
        check("rx nonempty 3", mem_din[1], 1'b0);
        op(1'b0, 32'h0003_0000, 8'h00);
        check("rx pop empty", mem_din, 8'h00);

        // Reset with bytes pending in TX
        for (int i = 0; i < 3; i++) op(1'b1, 32'h0003_0000, 8'h70 + 8'(i));
        rst = 1'b1;
        op(1'b1, 32'h0001_0010, 8'hFF);
        rst = 1'b0;
        check("post-reset tx_valid", io_tx_valid, 1'b0);
        check("post-reset bf", io_buffer_full, 1'b0);
        op(1'b0, 32'h0003_0004, 8'h00);
        check("post-reset status", mem_din, 8'h00);
        op(1'b0, 32'h0001_0010, 8'h00);
        check("ram survives reset", mem_din, 8'hA5);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            int          r;
            logic [31:0] a;
            logic        w;
            r           = $urandom_range(0, 99);
            rst         = ($urandom_range(0, 299) == 0);
            io_tx_ready = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            io_rx_valid = ($urandom_range(0, 2) == 0);
            io_rx_data  = 8'($urandom);
            w           = ($urandom_range(0, 1) == 1);
            if (r < 40)      a = 32'($urandom_range(0, 63)) | (($urandom_range(0, 1) == 1) ? 32'h0001_0000 : 32'h0);
            else if (r < 65) a = 32'h0003_0000;
            else if (r < 85) a = 32'h0003_0004;
            else if (r < 92) a = ($urandom_range(0, 1) == 1) ? 32'h0003_0008 : 32'h0003_0001;
            else begin
                a = 32'h0;
                w = 1'b0;
            end
            op(w, a, 8'($urandom));
        end

        cmp_en      = 1'b0;
        rst         = 1'b0;
        io_rx_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
